// File: rtl/bambu_mem_arbiter_pkg.sv
// Shared types and width defaults for the Bambu memory-channel arbiter.
package bambu_mem_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF  = 2;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int SIZE_W_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  // Grant index width; a 2-requester arbiter still needs one bit.
  function automatic int gnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bambu_mem_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request strictly after ptr, wrapping.
module bambu_mem_arbiter_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx   = W'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bambu_mem_arbiter.sv
// Round-robin arbiter sharing one Bambu memory channel among N_REQ masters, one transaction at a time.
// Optional per-requester grant/wait statistics counters are built when MEMARB_STATS_EN is defined.
module bambu_mem_arbiter
  import bambu_mem_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIZE_W = SIZE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_oe,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ*SIZE_W-1:0]    req_size,
  output logic [DATA_W-1:0]          req_rdata,
  output logic [N_REQ-1:0]           req_rdy,
  output logic                       mem_oe,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [SIZE_W-1:0]          mem_size,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_rdy,
  output logic                       proto_err
`ifdef MEMARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]     stat_grant,
  output logic [N_REQ*CNT_W-1:0]     stat_wait
`endif
);

  localparam int GNT_W = gnt_w(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || CNT_W < 1) begin : g_bad_cfg
    $error("bambu_mem_arbiter: unsupported N_REQ or CNT_W");
  end

  arb_state_t        state_q, state_d;
  logic [GNT_W-1:0]  gnt_q, gnt_d;
  logic [GNT_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              proto_err_q, proto_err_d;

  logic [N_REQ-1:0]  req_any;
  logic [GNT_W-1:0]  pick_idx;
  logic              pick_found;
  logic              active, owner_oe, owner_we;
  logic              err_now, drop_now, done_now;

  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];
  logic [SIZE_W-1:0] size_a  [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
      size_a[i]  = req_size[i*SIZE_W +: SIZE_W];
    end
  end

  assign req_any = req_oe | req_we;

  bambu_mem_arbiter_rr_pick #(
    .N (N_REQ),
    .W (GNT_W)
  ) u_rr_pick (
    .req   (req_any),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Outputs are forced quiet while reset is held, even before the reset edge.
  assign active   = reset && (state_q == BUSY);
  assign owner_oe = req_oe[gnt_q];
  assign owner_we = req_we[gnt_q];
  assign err_now  = active && owner_oe && owner_we;
  assign drop_now = active && !owner_oe && !owner_we;
  assign done_now = active && !err_now && !drop_now && mem_rdy;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= GNT_W'(N_REQ - 1);
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = proto_err_q | err_now;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (err_now || drop_now || done_now) begin
          rr_ptr_d = gnt_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    req_rdy   = '0;
    req_rdata = '0;
    if (active) begin
      mem_addr  = addr_a[gnt_q];
      mem_wdata = wdata_a[gnt_q];
      mem_size  = size_a[gnt_q];
      if (!err_now) begin
        mem_oe = owner_oe;
        mem_we = owner_we;
      end
      if (done_now) begin
        req_rdy[gnt_q] = 1'b1;
        req_rdata      = mem_rdata;
      end
    end
  end

  assign proto_err = proto_err_q && reset;

`ifdef MEMARB_STATS_EN
  logic [CNT_W-1:0] stat_grant_q [N_REQ];
  logic [CNT_W-1:0] stat_grant_d [N_REQ];
  logic [CNT_W-1:0] stat_wait_q  [N_REQ];
  logic [CNT_W-1:0] stat_wait_d  [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stat_grant_d[i] = stat_grant_q[i];
      stat_wait_d[i]  = stat_wait_q[i];
      if (done_now && gnt_q == GNT_W'(i) && stat_grant_q[i] != '1) begin
        stat_grant_d[i] = stat_grant_q[i] + 1'b1;
      end
      if (req_any[i] && !(state_q == BUSY && gnt_q == GNT_W'(i)) && stat_wait_q[i] != '1) begin
        stat_wait_d[i] = stat_wait_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (!reset) begin
        stat_grant_q[i] <= '0;
        stat_wait_q[i]  <= '0;
      end else begin
        stat_grant_q[i] <= stat_grant_d[i];
        stat_wait_q[i]  <= stat_wait_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stat_grant[i*CNT_W +: CNT_W] = reset ? stat_grant_q[i] : '0;
      stat_wait[i*CNT_W +: CNT_W]  = reset ? stat_wait_q[i]  : '0;
    end
  end
`endif

endmodule

// File: tb/tb_bambu_mem_arbiter.sv
// Scoreboard bench for bambu_mem_arbiter: a delay-programmable memory model answers each access,
// expected completions are queued when requests are driven and popped on every req_rdy pulse.
module tb_bambu_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_oe, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_size;
  logic [DW-1:0]   req_rdata;
  logic [N-1:0]    req_rdy;
  logic            mem_oe, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [SW-1:0]   mem_size;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_rdy = 1'b0;
  logic            proto_err;
`ifdef MEMARB_STATS_EN
  logic [N*CW-1:0] stat_grant, stat_wait;
`endif

  bambu_mem_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .CNT_W(CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_oe    (req_oe),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .req_rdata (req_rdata),
    .req_rdy   (req_rdy),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_size  (mem_size),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy),
    .proto_err (proto_err)
`ifdef MEMARB_STATS_EN
    ,
    .stat_grant(stat_grant),
    .stat_wait (stat_wait)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: DataRdy on the mem_delay-th consecutive cycle an access is presented.
  int mem_delay = 2;
  int busy_cnt  = 0;
  bit force_rdy = 1'b0;

  always @(posedge clock) begin
    #1;
    if (mem_oe || mem_we) begin
      busy_cnt++;
      mem_rdy   = (busy_cnt == mem_delay);
      mem_rdata = {1'b0, mem_addr} ^ 8'hA0;
    end else begin
      busy_cnt  = 0;
      mem_rdy   = force_rdy;
      mem_rdata = 8'h00;
    end
  end

  typedef struct packed {
    logic [N-1:0]  rdy;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_sample(output bit hit);
    exp_t e;
    hit = 1'b0;
    if (req_rdy != '0) begin
      hit = 1'b1;
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_rdy", 32'(req_rdy), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check_val("sb_rdy", 32'(req_rdy), 32'(e.rdy));
        check_val("sb_rdata", 32'(req_rdata), 32'(e.data));
      end
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit hit;
    cycles = 0;
    while (sb_q.size() > 0) begin
      @(negedge clock);
      cycles++;
      sb_sample(hit);
      if (cycles >= budget && sb_q.size() > 0) begin
        check_val("sb_timeout_left", 32'(sb_q.size()), 32'h0);
        sb_q.delete();
      end
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    req_oe = '0;
    req_we = '0;
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int c;
    bit hit;
    reset     = 1'b0;
    req_oe    = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = '0;
    repeat (3) @(negedge clock);
    check_val("rst_mem_oe", 32'(mem_oe), 32'h0);
    check_val("rst_mem_we", 32'(mem_we), 32'h0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_val("rst_req_rdy", 32'(req_rdy), 32'h0);
    check_val("rst_proto_err", 32'(proto_err), 32'h0);
    reset = 1'b1;

    // Stray DataRdy while idle must not produce a completion.
    force_rdy = 1'b1;
    repeat (2) @(negedge clock);
    check_val("idle_rdy_ignored", 32'(req_rdy), 32'h0);
    check_val("idle_mem_oe", 32'(mem_oe), 32'h0);
    force_rdy = 1'b0;
    @(negedge clock);

    // Single read from requester 0.
    mem_delay = 2;
    req_addr  = {7'h00, 7'h05};
    req_oe    = 2'b01;
    sb_q.push_back('{rdy: 2'b01, data: 8'hA5});
    @(negedge clock);
    check_val("rd_mem_oe", 32'(mem_oe), 32'h1);
    check_val("rd_mem_addr", 32'(mem_addr), 32'h05);
    check_val("rd_early_rdy", 32'(req_rdy), 32'h0);
    wait_done(20, c);
    check_val("rd_latency", 32'(c), 32'h1);
    @(negedge clock);
    check_val("rd_idle_gap_oe", 32'(mem_oe), 32'h0);
    check_val("rd_idle_gap_addr", 32'(mem_addr), 32'h0);
    req_oe = '0;

    // Contention: both read continuously from a fresh reset, order 0,1,0,1.
    do_reset();
    mem_delay = 2;
    req_addr  = {7'h02, 7'h01};
    req_oe    = 2'b11;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back((i % 2 == 0) ? exp_t'{rdy: 2'b01, data: 8'hA1}
                                  : exp_t'{rdy: 2'b10, data: 8'hA2});
    end
    wait_done(40, c);
    req_oe = '0;
    check_val("cont_cycles", 32'(c), 32'd11);
    @(negedge clock);

    // Write from requester 1, memory ready on the first cycle.
    mem_delay = 1;
    req_addr  = {7'h10, 7'h00};
    req_wdata = {8'h3C, 8'h00};
    req_size  = {4'd8, 4'd0};
    req_we    = 2'b10;
    sb_q.push_back('{rdy: 2'b10, data: 8'hB0});
    @(negedge clock);
    check_val("wr_mem_we", 32'(mem_we), 32'h1);
    check_val("wr_mem_oe", 32'(mem_oe), 32'h0);
    check_val("wr_mem_addr", 32'(mem_addr), 32'h10);
    check_val("wr_mem_wdata", 32'(mem_wdata), 32'h3C);
    check_val("wr_mem_size", 32'(mem_size), 32'd8);
    sb_sample(hit);
    check_val("wr_completed", 32'(hit), 32'h1);
    req_we = '0;
    @(negedge clock);

    // Protocol error by owner 0, then requester 1 served normally.
    mem_delay = 3;
    req_addr  = {7'h02, 7'h01};
    req_oe    = 2'b01;
    @(negedge clock);
    req_oe = 2'b11;
    req_we = 2'b01;
    #1;
    check_val("perr_mem_oe", 32'(mem_oe), 32'h0);
    check_val("perr_mem_we", 32'(mem_we), 32'h0);
    check_val("perr_no_rdy", 32'(req_rdy), 32'h0);
    @(negedge clock);
    check_val("perr_set", 32'(proto_err), 32'h1);
    req_oe = 2'b10;
    req_we = 2'b00;
    sb_q.push_back('{rdy: 2'b10, data: 8'hA2});
    wait_done(20, c);
    req_oe = '0;
    @(negedge clock);
    check_val("perr_sticky", 32'(proto_err), 32'h1);

    // Reset while waiting for DataRdy.
    mem_delay = 10;
    req_addr  = {7'h04, 7'h03};
    req_oe    = 2'b01;
    @(negedge clock);
    check_val("mid_busy_oe", 32'(mem_oe), 32'h1);
    reset  = 1'b0;
    req_oe = 2'b11;
    @(negedge clock);
    check_val("mid_rst_oe", 32'(mem_oe), 32'h0);
    check_val("mid_rst_addr", 32'(mem_addr), 32'h0);
    check_val("mid_rst_rdy", 32'(req_rdy), 32'h0);
    check_val("mid_rst_perr", 32'(proto_err), 32'h0);
    reset     = 1'b1;
    mem_delay = 2;
    sb_q.push_back('{rdy: 2'b01, data: 8'hA3});
    @(negedge clock);
    check_val("post_rst_oe", 32'(mem_oe), 32'h1);
    check_val("post_rst_addr", 32'(mem_addr), 32'h03);
    wait_done(20, c);
    req_oe = '0;
    @(negedge clock);

`ifdef MEMARB_STATS_EN
    do_reset();
    mem_delay = 4;
    req_addr  = {7'h02, 7'h01};
    req_oe    = 2'b11;
    sb_q.push_back('{rdy: 2'b01, data: 8'hA1});
    wait_done(20, c);
    req_oe = 2'b01;
    sb_q.push_back('{rdy: 2'b01, data: 8'hA1});
    sb_q.push_back('{rdy: 2'b01, data: 8'hA1});
    wait_done(40, c);
    req_oe = '0;
    @(negedge clock);
    check_val("stat_grant0", 32'(stat_grant[0 +: CW]), 32'd3);
    check_val("stat_wait1", 32'(stat_wait[CW +: CW]), 32'd4);
    check_val("stat_grant1", 32'(stat_grant[CW +: CW]), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
